// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and default widths for the FIFO read packer.
package fifo_rd_packer_pkg;

    localparam int PK_FIFO_WIDTH = 16;
    localparam int PK_CNT_WIDTH  = 16;

    // LOW: waiting for the first half of a pair; HIGH: low half held in lo.
    typedef enum logic [0:0] {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } pk_state_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word stream: 2*FIFO_WIDTH data with valid/ready and flush-pad flag.
interface fifo_rd_packer_if
    import fifo_rd_packer_pkg::*;
#(
    parameter int FIFO_WIDTH = PK_FIFO_WIDTH
) ();

    logic [2*FIFO_WIDTH-1:0] pk_data;
    logic                    pk_valid;
    logic                    pk_ready;
    logic                    pk_odd;

    modport master (output pk_data, output pk_valid, output pk_odd, input pk_ready);
    modport slave  (input pk_data, input pk_valid, input pk_odd, output pk_ready);

endinterface

// File: rtl/fifo_rd_packer_pk_out_reg.sv
// Two-half output register; contents held stable while valid && !ready.
module pk_out_reg
    import fifo_rd_packer_pkg::*;
#(
    parameter int FIFO_WIDTH = PK_FIFO_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [2*FIFO_WIDTH-1:0] load_data,
    input  logic                    load_odd,
    input  logic                    ready,
    output logic [2*FIFO_WIDTH-1:0] data,
    output logic                    valid,
    output logic                    odd,
    output logic                    fire
);

    assign fire = valid & ready;

    // Load takes priority so a fire and a load in one cycle go back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            odd   <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            odd   <= load_odd;
            valid <= 1'b1;
        end else if (fire) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads FIFO half-words and packs pairs into double-width words, with flush padding.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int FIFO_WIDTH = PK_FIFO_WIDTH,
    parameter int CNT_WIDTH  = PK_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic                  rd_en,
    input  logic                  flush,
    fifo_rd_packer_if.master      pk,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  err_underflow
);

    pk_state_e               state;
    logic [FIFO_WIDTH-1:0]   lo;
    logic                    lo_valid;
    logic                    inflight;
    logic                    flush_pend;
    logic                    flush_req;
    logic                    flush_go;
    logic                    flush_nop;
    logic                    pair_go;
    logic                    load;
    logic [2*FIFO_WIDTH-1:0] load_data;
    logic                    out_valid;
    logic                    out_fire;
    logic                    out_busy;
    logic [2*FIFO_WIDTH-1:0] out_data;
    logic                    out_odd;
    logic [2:0]              committed;

    assign lo_valid  = (state == ST_HIGH);
    assign out_busy  = out_valid & ~out_fire;
    assign flush_req = flush | flush_pend;

    // A pair loads only when the output register is free or firing. The read
    // gate below keeps at most 3 halves committed, so whenever a high half is
    // captured the output register can take the pair and nothing is dropped.
    assign pair_go   = inflight & lo_valid & ~out_busy;
    assign flush_go  = flush_req & lo_valid & ~inflight & ~out_busy;
    assign flush_nop = flush_req & ~lo_valid & ~inflight;
    assign load      = pair_go | flush_go;
    assign load_data = flush_go ? {{FIFO_WIDTH{1'b0}}, lo} : {data_out, lo};

    // Halves held: lo, the read in flight, and a non-departing output word.
    assign committed = {2'b00, lo_valid} + {2'b00, inflight} + {1'b0, out_busy, 1'b0};

    // Reads also pause while a flush is pending so the padded word only ever
    // holds halves read before the flush request.
    assign rd_en = rst_n & ~empty & ~flush & ~flush_pend & (committed <= 3'd2);

    // Control FSM, in-flight tracking, flush pending, counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_LOW;
            lo            <= '0;
            inflight      <= 1'b0;
            flush_pend    <= 1'b0;
            word_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight   <= rd_en;
            flush_pend <= flush_req & ~flush_go & ~flush_nop;
            if (inflight && state == ST_LOW) begin
                lo    <= data_out;
                state <= ST_HIGH;
            end else if (load) begin
                state <= ST_LOW;
            end
            if (out_fire) begin
                word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (inflight && underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    pk_out_reg #(
        .FIFO_WIDTH(FIFO_WIDTH)
    ) u_pk_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .load_odd (flush_go),
        .ready    (pk.pk_ready),
        .data     (out_data),
        .valid    (out_valid),
        .odd      (out_odd),
        .fire     (out_fire)
    );

    assign pk.pk_data  = out_data;
    assign pk.pk_valid = out_valid;
    assign pk.pk_odd   = out_odd;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO model, pairing reference, monitor.
module tb_fifo_rd_packer;
    import fifo_rd_packer_pkg::*;

    localparam int W  = PK_FIFO_WIDTH;
    localparam int CW = PK_CNT_WIDTH;

    typedef struct packed {
        logic [2*W-1:0] data;
        logic           odd;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_out = '0;
    logic          empty = 1'b1;
    logic          underflow = 1'b0;
    logic          flush = 1'b0;
    logic          rd_en;
    logic [CW-1:0] word_cnt;
    logic          err_underflow;

    fifo_rd_packer_if #(.FIFO_WIDTH(W)) pk_if ();

    fifo_rd_packer #(
        .FIFO_WIDTH(W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_out     (data_out),
        .empty        (empty),
        .underflow    (underflow),
        .rd_en        (rd_en),
        .flush        (flush),
        .pk           (pk_if),
        .word_cnt     (word_cnt),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] fifo_q[$];
    word_t        exp_q[$];
    logic [W-1:0] ref_half;
    bit           ref_has = 0;
    int           pops = 0;
    int           emitted = 0;
    int           fires = 0;
    int           ready_mode = 2;
    bit           rd_s = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: consecutive FIFO words pair up, first one in the low half.
    task automatic write_word(input logic [W-1:0] w);
        word_t e;
        fifo_q.push_back(w);
        empty = 1'b0;
        if (ref_has) begin
            e.data = {w, ref_half};
            e.odd  = 1'b0;
            exp_q.push_back(e);
            ref_has = 0;
        end else begin
            ref_half = w;
            ref_has  = 1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
            step(1);
            n++;
        end
        chk("drain_words_left", exp_q.size() + fifo_q.size(), 0);
    endtask

    task automatic do_flush();
        word_t e;
        int n = 0;
        while (fifo_q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        chk("flush_fifo_drained", fifo_q.size(), 0);
        step(3);
        if (ref_has) begin
            e.data = {{W{1'b0}}, ref_half};
            e.odd  = 1'b1;
            exp_q.push_back(e);
            ref_has = 0;
        end
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    // FIFO model: a read granted at an edge presents its word just after it.
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) begin
            data_out = fifo_q.pop_front();
            pops++;
        end
        empty = (fifo_q.size() == 0);
    end

    // Consumer ready pattern.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       pk_if.pk_ready = 1'b1;
            1:       pk_if.pk_ready = 1'($urandom_range(0, 1));
            default: pk_if.pk_ready = 1'b0;
        endcase
    end

    // Monitor: sampled on the falling edge, compares every fired word.
    initial begin : monitor
        bit    hold = 0;
        word_t prev;
        word_t e;
        forever begin
            @(negedge clk);
            rd_s = rd_en;
            if (!rst_n) begin
                hold = 0;
                continue;
            end
            if (rd_en) chk("rd_en_while_empty", empty, 0);
            if (hold) begin
                chk("hold_valid", pk_if.pk_valid, 1);
                chk("hold_word", {pk_if.pk_data, pk_if.pk_odd}, {prev.data, prev.odd});
            end
            if (pk_if.pk_valid && pk_if.pk_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", pk_if.pk_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pk_data", pk_if.pk_data, e.data);
                    chk("pk_odd", pk_if.pk_odd, e.odd);
                end
                chk("word_cnt_at_fire", word_cnt, fires % (1 << CW));
                fires++;
                emitted += pk_if.pk_odd ? 1 : 2;
            end
            chk("halves_committed_le3", (pops - emitted) <= 3, 1);
            hold      = pk_if.pk_valid && !pk_if.pk_ready;
            prev.data = pk_if.pk_data;
            prev.odd  = pk_if.pk_odd;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pk_if.pk_ready = 1'b0;
        // Reset values with a word waiting in the FIFO.
        write_word(16'h1111);
        #12;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_pk_data", pk_if.pk_data, 0);
        chk("rst_pk_valid", pk_if.pk_valid, 0);
        chk("rst_pk_odd", pk_if.pk_odd, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_err", err_underflow, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ready_mode = 0;

        // Basic pair.
        write_word(16'h2222);
        wait_drain(50);
        step(2);
        chk("basic_word_cnt", word_cnt, 1);

        // Back-pressure: at most 3 halves committed, then in-order release.
        ready_mode = 2;
        step(1);
        for (int i = 1; i <= 8; i++) write_word(16'(i));
        step(20);
        chk("stall_rd_en", rd_en, 0);
        chk("stall_halves_held", pops - emitted, 3);
        chk("stall_fifo_left", fifo_q.size(), 5);
        ready_mode = 0;
        wait_drain(100);
        step(2);
        chk("stall_word_cnt", word_cnt, 5);

        // Flush of a lone half, then a normal pair.
        write_word(16'hABCD);
        do_flush();
        write_word(16'h1234);
        write_word(16'h5678);
        wait_drain(50);
        step(2);
        chk("flush_word_cnt", word_cnt, 7);

        // Flush with nothing stored is a no-op.
        do_flush();
        step(4);
        chk("noop_flush_valid", pk_if.pk_valid, 0);
        chk("noop_flush_cnt", word_cnt, 7);

        // Continuous stream of 16 words.
        for (int i = 0; i < 16; i++) write_word(16'h4000 + 16'(i));
        wait_drain(100);
        step(2);
        chk("stream_word_cnt", word_cnt, 15);
        chk("stream_err", err_underflow, 0);

        // Underflow without a read in flight is ignored.
        underflow = 1'b1;
        step(3);
        underflow = 1'b0;
        step(1);
        chk("uf_idle_err", err_underflow, 0);

        // Randomized traffic with random back-pressure and occasional flushes.
        ready_mode = 1;
        for (int it = 0; it < 10; it++) begin
            int n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) begin
                write_word(16'($urandom));
                step($urandom_range(0, 2));
            end
            if ($urandom_range(0, 2) == 0) do_flush();
        end
        do_flush();
        wait_drain(600);
        ready_mode = 0;
        step(3);
        chk("random_word_cnt", word_cnt, fires % (1 << CW));

        // Underflow flagged on the cycle after a read; sticky.
        write_word(16'h5A5A);
        begin
            int n = 0;
            while (n < 20) begin
                @(negedge clk);
                if (rd_en) break;
                n++;
            end
            chk("uf_saw_rd_en", n < 20, 1);
        end
        @(posedge clk);
        #2;
        underflow = 1'b1;
        step(1);
        underflow = 1'b0;
        step(2);
        chk("uf_err_set", err_underflow, 1);
        do_flush();
        wait_drain(50);
        step(10);
        chk("uf_err_sticky", err_underflow, 1);

        // Asynchronous reset mid-operation with lo and output register full.
        ready_mode = 2;
        step(1);
        for (int i = 1; i <= 4; i++) write_word(16'hC000 + 16'(i));
        step(10);
        chk("pre_rst_pk_valid", pk_if.pk_valid, 1);
        chk("pre_rst_halves", pops - emitted, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        empty = 1'b1;
        ref_has = 0;
        pops = 0;
        emitted = 0;
        fires = 0;
        #1;
        chk("arst_rd_en", rd_en, 0);
        chk("arst_pk_data", pk_if.pk_data, 0);
        chk("arst_pk_valid", pk_if.pk_valid, 0);
        chk("arst_pk_odd", pk_if.pk_odd, 0);
        chk("arst_word_cnt", word_cnt, 0);
        chk("arst_err", err_underflow, 0);
        step(2);
        rst_n = 1'b1;
        ready_mode = 0;
        write_word(16'hAAAA);
        write_word(16'hBBBB);
        wait_drain(50);
        step(2);
        chk("post_rst_word_cnt", word_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, meaning the FIFO data word width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the output word counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_out, input, FIFO_WIDTH bits: FIFO read data, valid one cycle after a granted rd_en.
REQ-006 The block SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port underflow, input, 1 bit: FIFO underflow flag.
REQ-008 The block SHALL have port rd_en, output, 1 bit: FIFO read request.
REQ-009 The block SHALL have port flush, input, 1 bit: a one-cycle pulse that emits any lone half-word as a padded word.
REQ-010 The block SHALL have port pk_data, output, 2*FIFO_WIDTH bits: packed word, first-read half in the low bits.
REQ-011 The block SHALL have port pk_valid, output, 1 bit: pk_data holds a word.
REQ-012 The block SHALL have port pk_ready, input, 1 bit: the consumer accepts a word.
REQ-013 The block SHALL have port pk_odd, output, 1 bit: the current word is flush-padded (high half zero).
REQ-014 The block SHALL have port word_cnt, output, CNT_WIDTH bits: count of accepted words.
REQ-015 The block SHALL have port err_underflow, output, 1 bit: sticky underflow error.

Function
REQ-016 The block SHALL define a fire as pk_valid && pk_ready in the same cycle; pk_data, pk_odd and pk_valid SHALL stay stable while pk_valid && !pk_ready.
REQ-017 The block SHALL hold storage for 3 halves: a low-half register (lo_valid) and a 2-half output register (pk_valid); a read in flight (inflight) SHALL count as one committed half.
REQ-018 The block SHALL assert rd_en only when all three hold: empty==0; flush==0; and lo_valid + inflight + 2*(pk_valid && !fire) <= 2.
REQ-019 The block SHALL set inflight on the cycle after rd_en and capture data_out in that cycle.
REQ-020 The block SHALL run a state machine with states LOW and HIGH, reset to LOW.
REQ-021 In LOW, the block SHALL store a captured half into lo and move to HIGH.
REQ-022 In HIGH, the block SHALL load {captured, lo} into the output register (pk_odd=0), clear lo_valid and move to LOW.
REQ-023 In HIGH with the output register occupied and not firing, the block SHALL stall the load until that register frees; REQ-018 SHALL guarantee that no captured half is ever lost.
REQ-024 The block SHALL make a word loaded in cycle N visible as pk_valid in cycle N+1; a fire and a load in the same cycle SHALL produce back-to-back words with no bubble.
REQ-025 Flush with lo_valid=1, inflight=0 and the output register free-or-firing SHALL load {0, lo}, set pk_odd=1 and return to LOW.
REQ-026 Flush in any other case SHALL be held pending and executed when the REQ-025 conditions are met, with a captured in-flight half completing the pair first.
REQ-027 Flush with nothing stored and nothing in flight SHALL be a no-op.
REQ-028 The block SHALL increment word_cnt by 1 on each fire, wrapping modulo 2^CNT_WIDTH.
REQ-029 The block SHALL set err_underflow when underflow==1 in the cycle after rd_en, and it SHALL stay set until reset.

Reset
REQ-030 While rst_n==0, all outputs SHALL be 0 (rd_en, pk_data, pk_valid, pk_odd, word_cnt, err_underflow) and lo_valid, inflight and flush-pending SHALL be cleared, state = LOW.
REQ-031 Reset asserted mid-operation SHALL discard buffered and in-flight halves; FIFO data read but not yet packed is lost by design.

Structure
REQ-032 A shared package SHALL hold the state enum (LOW, HIGH) and the default FIFO_WIDTH/CNT_WIDTH constants.
REQ-033 The block SHALL be built from one sub-module, pk_out_reg (2-half output register with valid/ready hold), plus the control FSM in the top.

Verification
REQ-034 Reset, then FIFO writes 0x1111,0x2222, pk_ready=1 -> pk_data=0x22221111, pk_odd=0, word_cnt=1.
REQ-035 Write 8 words 0x0001..0x0008, pk_ready=0 for 20 cycles then 1 -> no more than 3 halves committed, rd_en stops, then 4 words in order 0x00020001..0x00080007, no loss.
REQ-036 Write 0xABCD then flush pulse -> pk_data=0x0000ABCD, pk_odd=1; a following write of 0x1234,0x5678 -> 0x56781234, pk_odd=0.
REQ-037 Continuous stream of 16 words with pk_ready=1 -> rd_en never asserted while empty=1, 8 words out, word_cnt=8, err_underflow=0.
REQ-038 Force underflow=1 after a rd_en -> err_underflow=1, held until rst_n=0.
REQ-039 Assert rst_n=0 with lo_valid=1 and pk_valid=1 -> all outputs 0 immediately (asynchronous), and the next pair after release packs correctly.
